// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the D-cache: queues line fills and committed stores and
// services them over one word-wide memory port, returning each filled line as a one-cycle pulse.
module dcache_mem_responder #(
  parameter int TAG_BITS    = 20,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 5,
  parameter int DATA_W      = 32,
  parameter int LDQ_DEPTH   = 4,
  parameter int STQ_DEPTH   = 4,
  parameter int MISS_LAT    = 0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [TAG_BITS+INDEX_BITS-1:0]             dc2memLdAddr_i,
  input  logic                                       dc2memLdValid_i,
  output logic [TAG_BITS-1:0]                        mem2dcLdTag_o,
  output logic [INDEX_BITS-1:0]                      mem2dcLdIndex_o,
  output logic [8*(2**OFFSET_BITS)-1:0]              mem2dcLdData_o,
  output logic                                       mem2dcLdValid_o,
  input  logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-3:0] dc2memStAddr_i,
  input  logic [DATA_W-1:0]                          dc2memStData_i,
  input  logic [3:0]                                 dc2memStByteEn_i,
  input  logic                                       dc2memStValid_i,
  output logic                                       mem2dcStComplete_o,
  output logic                                       mem2dcStStall_o,
  output logic [TAG_BITS+INDEX_BITS+OFFSET_BITS-3:0] mem_addr_o,
  output logic                                       mem_rd_en_o,
  input  logic [DATA_W-1:0]                          mem_rd_data_i,
  output logic                                       mem_wr_en_o,
  output logic [DATA_W-1:0]                          mem_wr_data_o,
  output logic [3:0]                                 mem_wr_be_o,
  output logic                                       ld_overflow_o
);
  localparam int LINE_W = 8 * (2 ** OFFSET_BITS);
  localparam int WORDS  = LINE_W / DATA_W;
  localparam int WB     = $clog2(WORDS);
  localparam int LA_W   = TAG_BITS + INDEX_BITS;
  localparam int WA_W   = LA_W + OFFSET_BITS - 2;
  localparam int LQ_AW  = $clog2(LDQ_DEPTH);
  localparam int SQ_AW  = $clog2(STQ_DEPTH);
  localparam int ST_W   = WA_W + DATA_W + 4;
  localparam logic [LQ_AW:0] LQ_ONE = 1;
  localparam logic [SQ_AW:0] SQ_ONE = 1;
  localparam logic [WB-1:0]  WB_ONE = 1;

  typedef enum logic [2:0] {IDLE, ST_WRITE, LD_READ, LD_WAIT, LD_RESP} stateT;
  stateT state;

  logic [LA_W-1:0] ldqMem [LDQ_DEPTH];
  logic [LQ_AW:0]  ldqWrPtr, ldqRdPtr, ldqCount;
  logic            ldqFull, ldqEmpty, ldqPush, ldqPop;

  logic [ST_W-1:0] stqMem [STQ_DEPTH];
  logic [SQ_AW:0]  stqWrPtr, stqRdPtr, stqCount, stqCountNext;
  logic            stqFull, stqEmpty, stqPush, stqPop;

  logic [LA_W-1:0]   lineAddr;
  logic [WB-1:0]     wordCnt, capIdx;
  logic              capEn;
  logic [7:0]        latCnt;
  logic [LINE_W-1:0] lineBuf, lineBufNext;

  assign ldqCount = ldqWrPtr - ldqRdPtr;
  assign ldqFull  = (ldqCount == (LQ_AW+1)'(LDQ_DEPTH));
  assign ldqEmpty = (ldqCount == '0);
  assign stqCount = stqWrPtr - stqRdPtr;
  assign stqFull  = (stqCount == (SQ_AW+1)'(STQ_DEPTH));
  assign stqEmpty = (stqCount == '0);

  assign ldqPush = dc2memLdValid_i && !ldqFull;
  assign stqPush = dc2memStValid_i && !stqFull;
  // Stores drain first so every fill observes all previously accepted stores.
  assign stqPop  = (state == IDLE) && !stqEmpty;
  assign ldqPop  = (state == IDLE) && stqEmpty && !ldqEmpty;

  always_comb begin
    stqCountNext = stqCount;
    if (stqPush && !stqPop)
      stqCountNext = stqCount + SQ_ONE;
    else if (!stqPush && stqPop)
      stqCountNext = stqCount - SQ_ONE;
  end

  always_ff @(posedge clk) begin
    if (ldqPush) ldqMem[ldqWrPtr[LQ_AW-1:0]] <= dc2memLdAddr_i;
    if (stqPush) stqMem[stqWrPtr[SQ_AW-1:0]] <= {dc2memStAddr_i, dc2memStData_i, dc2memStByteEn_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldqWrPtr        <= '0;
      ldqRdPtr        <= '0;
      stqWrPtr        <= '0;
      stqRdPtr        <= '0;
      ld_overflow_o   <= 1'b0;
      mem2dcStStall_o <= 1'b0;
    end else begin
      if (ldqPush) ldqWrPtr <= ldqWrPtr + LQ_ONE;
      if (ldqPop)  ldqRdPtr <= ldqRdPtr + LQ_ONE;
      if (stqPush) stqWrPtr <= stqWrPtr + SQ_ONE;
      if (stqPop)  stqRdPtr <= stqRdPtr + SQ_ONE;
      if (dc2memLdValid_i && ldqFull) ld_overflow_o <= 1'b1;
      // Asserted one entry early so a store already in flight still fits.
      mem2dcStStall_o <= (stqCountNext >= (SQ_AW+1)'(STQ_DEPTH - 1));
    end
  end

  // Read data arrives the cycle after its read; merge it into the word it was issued for.
  for (genvar gi = 0; gi < WORDS; gi++) begin : gCapture
    assign lineBufNext[gi*DATA_W +: DATA_W] =
      (capEn && capIdx == WB'(gi)) ? mem_rd_data_i : lineBuf[gi*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      lineAddr           <= '0;
      wordCnt            <= '0;
      capIdx             <= '0;
      capEn              <= 1'b0;
      latCnt             <= '0;
      lineBuf            <= '0;
      mem_addr_o         <= '0;
      mem_rd_en_o        <= 1'b0;
      mem_wr_en_o        <= 1'b0;
      mem_wr_data_o      <= '0;
      mem_wr_be_o        <= '0;
      mem2dcStComplete_o <= 1'b0;
      mem2dcLdValid_o    <= 1'b0;
      mem2dcLdTag_o      <= '0;
      mem2dcLdIndex_o    <= '0;
      mem2dcLdData_o     <= '0;
    end else begin
      lineBuf            <= lineBufNext;
      capEn              <= mem_rd_en_o;
      capIdx             <= mem_addr_o[WB-1:0];
      mem2dcStComplete_o <= 1'b0;
      case (state)
        IDLE: begin
          if (stqPop) begin
            {mem_addr_o, mem_wr_data_o, mem_wr_be_o} <= stqMem[stqRdPtr[SQ_AW-1:0]];
            mem_wr_en_o <= 1'b1;
            state       <= ST_WRITE;
          end else if (ldqPop) begin
            lineAddr    <= ldqMem[ldqRdPtr[LQ_AW-1:0]];
            mem_addr_o  <= {ldqMem[ldqRdPtr[LQ_AW-1:0]], {WB{1'b0}}};
            mem_rd_en_o <= 1'b1;
            wordCnt     <= '0;
            state       <= LD_READ;
          end
        end
        ST_WRITE: begin
          mem_wr_en_o        <= 1'b0;
          mem2dcStComplete_o <= 1'b1;
          state              <= IDLE;
        end
        LD_READ: begin
          if (wordCnt == WB'(WORDS - 1)) begin
            mem_rd_en_o <= 1'b0;
            latCnt      <= 8'(MISS_LAT);
            state       <= LD_WAIT;
          end else begin
            wordCnt    <= wordCnt + WB_ONE;
            mem_addr_o <= {lineAddr, wordCnt + WB_ONE};
          end
        end
        LD_WAIT: begin
          if (latCnt == 8'd0) begin
            mem2dcLdValid_o <= 1'b1;
            mem2dcLdTag_o   <= lineAddr[LA_W-1:INDEX_BITS];
            mem2dcLdIndex_o <= lineAddr[INDEX_BITS-1:0];
            mem2dcLdData_o  <= lineBufNext;
            state           <= LD_RESP;
          end else begin
            latCnt <= latCnt - 8'd1;
          end
        end
        LD_RESP: begin
          mem2dcLdValid_o <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Memory-side responder for the data-cache miss/store interface driven by the LSU.
- Accepts line-fill requests and committed store writes from the D-cache.
- Services both over a single word-wide memory port and returns assembled lines as single-cycle fill pulses.
- Sits between the LSU's D-cache and the backing memory or its behavioural model.

Parameters:
TAG_BITS, 20, D-cache tag width
INDEX_BITS, 6, D-cache index width
OFFSET_BITS, 5, log2 of bytes per line (line = 2^OFFSET_BITS bytes)
DATA_W, 32, store/memory word width
LDQ_DEPTH, 4, load-request queue entries (power of 2)
STQ_DEPTH, 4, store queue entries (power of 2, >=2)
MISS_LAT, 0, extra wait cycles before each fill response (0..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
dc2memLdAddr_i  in  TAG_BITS+INDEX_BITS  line address of fill request
dc2memLdValid_i  in  1  one-cycle fill request strobe
mem2dcLdTag_o  out  TAG_BITS  tag of returned line
mem2dcLdIndex_o  out  INDEX_BITS  index of returned line
mem2dcLdData_o  out  8*2^OFFSET_BITS  line data, word 0 in bits [DATA_W-1:0]
mem2dcLdValid_o  out  1  one-cycle fill strobe
dc2memStAddr_i  in  TAG_BITS+INDEX_BITS+OFFSET_BITS-2  word address of store
dc2memStData_i  in  DATA_W  store data
dc2memStByteEn_i  in  4  store byte enables
dc2memStValid_i  in  1  store strobe
mem2dcStComplete_o  out  1  one-cycle pulse per store written
mem2dcStStall_o  out  1  store queue near full; cache must not send further stores
mem_addr_o  out  TAG_BITS+INDEX_BITS+OFFSET_BITS-2  memory word address
mem_rd_en_o  out  1  read enable; data returns next cycle
mem_rd_data_i  in  DATA_W  read data, valid the cycle after mem_rd_en_o
mem_wr_en_o  out  1  write enable
mem_wr_data_o  out  DATA_W  write data
mem_wr_be_o  out  4  write byte enables
ld_overflow_o  out  1  sticky: fill request dropped because LDQ was full

Behaviour:
- W = 2^OFFSET_BITS*8/DATA_W words per line.
- Reset (reset==0, asynchronous): both queues emptied, FSM to IDLE, counters cleared, all outputs 0. Reset mid-line aborts that line; no fill or complete pulse is issued for it.
- Load queue:
  - dc2memLdValid_i with LDQ not full enqueues the address at the clock edge.
  - If LDQ is full, the request is dropped and ld_overflow_o sets; it clears only on reset.
- Store queue:
  - dc2memStValid_i enqueues {addr, data, be}.
  - mem2dcStStall_o is registered and is 1 while occupancy >= STQ_DEPTH-1, so one in-flight store still fits.
  - A store arriving when STQ is full is dropped (protocol violation).
- Simultaneous enqueue and dequeue on the same queue are legal in the same cycle; queue pointers wrap modulo depth.
- FSM states: IDLE, ST_WRITE, LD_READ, LD_WAIT, LD_RESP.
- IDLE:
  - If STQ is non-empty: pop the STQ head and go to ST_WRITE. Stores have priority, so fills observe all previously accepted stores.
  - Else if LDQ is non-empty: pop the LDQ head, clear the word counter, and go to LD_READ.
- ST_WRITE: one cycle with mem_wr_en_o=1 and addr/data/be from the popped entry. mem2dcStComplete_o pulses the next cycle. Return to IDLE.
- LD_READ:
  - Issue W consecutive reads, one per cycle: address = {line addr, word k}, k = 0..W-1.
  - Read data k is captured into line-buffer word k in the cycle after its read.
  - After the last read issues, go to LD_WAIT.
- LD_WAIT:
  - Wait one cycle for the final read data.
  - Then count MISS_LAT further cycles with an 8-bit down-counter.
  - Then go to LD_RESP.
- LD_RESP:
  - mem2dcLdValid_o=1 for one cycle, with tag, index and data held stable that cycle; return to IDLE.
  - Tag/index/data outputs hold their last value otherwise.
- A line in progress is never preempted by stores; stores wait until IDLE.
- Latency, idle queues:
  - Store request in cycle 0 gives mem_wr_en_o in cycle 2 and mem2dcStComplete_o in cycle 3.
  - Fill request in cycle 0 gives reads in cycles 2..W+1 and mem2dcLdValid_o in cycle W+3+MISS_LAT.
- Fills return in request order.
- mem_rd_en_o and mem_wr_en_o are never high in the same cycle.

Test Plan:
- Reset then one fill at address 0x0123, W=8, MISS_LAT=0, memory word i = i -> mem2dcLdValid_o in cycle 11, tag 0x4, index 0x23, data words 0..7 = 0..7, exactly one pulse.
- Store in cycle 0 to word address 0x48D, data 0xDEADBEEF, be 4'b0011 -> mem_wr_en_o in cycle 2 with matching addr/data/be; mem2dcStComplete_o in cycle 3 only.
- Fill and store strobed in the same cycle -> store written first (cycle 2); fill reads start cycle 4; fill response reflects the store bytes.
- Five back-to-back fills with LDQ_DEPTH=4 while busy -> fifth dropped, ld_overflow_o=1 until reset; four responses in request order.
- Three stores back-to-back with STQ_DEPTH=4 while a line is in progress -> mem2dcStStall_o rises once occupancy reaches 3; falls after the first drain; three complete pulses.
- Reset asserted during LD_READ word 3 -> all outputs 0 immediately; after release, no fill pulse appears and a new fill completes normally.
